mem_access_unit: RTL and testbench

- Parametrised load/store unit for the MEM stage.
- Generalises byte-lane select, store-data replication, load extraction with sign/zero extension, and address-error detection to DATA_W of 32 or 64.
- Adds a sequential request/response handshake to an SRAM-like data bus, with pipeline backpressure and flush/drain.
- Sits between the MEM pipeline register and the data-side bus port of the CPU top.

---
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mem_access_unit.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: SRAM-like data-side bus between the MEM-stage
// load/store unit (master) and the data memory / bus bridge (slave).
// One request beat (data_req/data_addr_ok) is followed by one response
// beat (data_data_ok/data_rdata).
interface mem_access_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                  data_req;
   logic                  data_wr;
   logic [1:0]            data_size;
   logic [ADDR_W-1:0]     data_addr;
   logic [DATA_W/8-1:0]   data_wstrb;
   logic [DATA_W-1:0]     data_wdata;
   logic                  data_addr_ok;
   logic                  data_data_ok;
   logic [DATA_W-1:0]     data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit for DATA_W = 32 or 64.
// Latches one op at a time, checks alignment, drives a single request beat
// on the data bus, then extracts/extends the load lane from the response.
// Misaligned ops fault locally without touching the bus. A flush cancels
// the op; an already-accepted bus request is drained silently.
// Optional feature macro: MEM_ACCESS_PERF_EN adds perf_access_cnt and
// perf_stall_cnt outputs.
module mem_access_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic              op_store,
   input  logic [1:0]        op_size,
   input  logic              op_unsigned,
   input  logic [ADDR_W-1:0] op_addr,
   input  logic [DATA_W-1:0] op_wdata,
   input  logic              flush,
   output logic              result_valid,
   output logic [DATA_W-1:0] load_data,
   output logic              adel,
   output logic              ades,
   output logic [ADDR_W-1:0] bad_vaddr,
`ifdef MEM_ACCESS_PERF_EN
   output logic [31:0]       perf_access_cnt,
   output logic [31:0]       perf_stall_cnt,
`endif
   mem_access_unit_if.master bus
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_RESP  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   // Byte-enable pattern of an access size, before lane shifting.
   function automatic logic [STRB_W-1:0] size_mask(input logic [1:0] size);
      logic [7:0] m;
      case (size)
         2'd0:    m = 8'h01;
         2'd1:    m = 8'h03;
         2'd2:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return STRB_W'(m);
   endfunction

   // Store data copied into every lane so any byte offset finds it.
   function automatic logic [DATA_W-1:0] replicate(input logic [1:0] size,
                                                   input logic [DATA_W-1:0] w);
      logic [DATA_W-1:0] r;
      case (size)
         2'd0:    r = {STRB_W{w[7:0]}};
         2'd1:    r = {(DATA_W/16){w[15:0]}};
         2'd2:    r = {(DATA_W/32){w[31:0]}};
         default: r = w;
      endcase
      return r;
   endfunction

   // Natural alignment check; a dword on a 32-bit bus can never be served.
   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
      logic m;
      case (size)
         2'd0:    m = 1'b0;
         2'd1:    m = a[0];
         2'd2:    m = (a[1:0] != 2'b00);
         default: m = (DATA_W == 64) ? (a != 3'b000) : 1'b1;
      endcase
      return m;
   endfunction

   // Lane select then sign/zero extension: move the lane to the top and
   // shift it back down logically or arithmetically.
   function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] rdata,
                                                 input logic [OFF_W-1:0]  off,
                                                 input logic [1:0]        size,
                                                 input logic              uns);
      logic [DATA_W-1:0] sh;
      logic [DATA_W-1:0] top;
      logic [6:0]        k;
      logic [DATA_W-1:0] r;
      sh = rdata >> {off, 3'b000};
      case (size)
         2'd0:    k = 7'(DATA_W - 8);
         2'd1:    k = 7'(DATA_W - 16);
         2'd2:    k = 7'(DATA_W - 32);
         default: k = 7'd0;
      endcase
      top = sh << k;
      if (uns) begin
         r = top >> k;
      end else begin
         r = $unsigned($signed(top) >>> k);
      end
      return r;
   endfunction

   state_t              state_q, state_d;
   logic                req_q, req_d;
   logic                store_q, store_d;
   logic [1:0]          size_q, size_d;
   logic                unsigned_q, unsigned_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [OFF_W-1:0]    off_q, off_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                result_valid_q, result_valid_d;
   logic                adel_q, adel_d;
   logic                ades_q, ades_d;
   logic                mis_pend_q, mis_pend_d;
   logic [DATA_W-1:0]   load_data_q, load_data_d;
   logic [ADDR_W-1:0]   bad_vaddr_q, bad_vaddr_d;
   logic                mis_kill;

   // Next-state, latch and result computation for the four-state op FSM.
   always_comb begin
      state_d        = state_q;
      req_d          = req_q;
      store_d        = store_q;
      size_d         = size_q;
      unsigned_d     = unsigned_q;
      addr_d         = addr_q;
      off_d          = off_q;
      wstrb_d        = wstrb_q;
      wdata_d        = wdata_q;
      result_valid_d = 1'b0;
      adel_d         = 1'b0;
      ades_d         = 1'b0;
      mis_pend_d     = 1'b0;
      load_data_d    = load_data_q;
      bad_vaddr_d    = bad_vaddr_q;
      case (state_q)
         S_IDLE: begin
            if (op_valid && !flush) begin
               store_d    = op_store;
               size_d     = op_size;
               unsigned_d = op_unsigned;
               addr_d     = op_addr;
               off_d      = op_addr[OFF_W-1:0];
               wstrb_d    = size_mask(op_size) << op_addr[OFF_W-1:0];
               wdata_d    = replicate(op_size, op_wdata);
               if (misaligned(op_size, op_addr[2:0])) begin
                  result_valid_d = 1'b1;
                  adel_d         = !op_store;
                  ades_d         = op_store;
                  mis_pend_d     = 1'b1;
                  bad_vaddr_d    = op_addr;
                  load_data_d    = {DATA_W{1'b0}};
               end else begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (bus.data_addr_ok) begin
               req_d   = 1'b0;
               state_d = flush ? S_DRAIN : S_RESP;
            end else if (flush) begin
               req_d   = 1'b0;
               state_d = S_IDLE;
            end else begin
               req_d   = 1'b1;
               state_d = S_REQ;
            end
         end
         S_RESP: begin
            if (bus.data_data_ok) begin
               state_d = S_IDLE;
               if (!flush) begin
                  result_valid_d = 1'b1;
                  load_data_d    = store_q ? {DATA_W{1'b0}}
                                           : extract(bus.data_rdata, off_q, size_q, unsigned_q);
               end else begin
                  result_valid_d = 1'b0;
               end
            end else if (flush) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_RESP;
            end
         end
         S_DRAIN: begin
            if (bus.data_data_ok) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q        <= S_IDLE;
         req_q          <= 1'b0;
         store_q        <= 1'b0;
         size_q         <= 2'd0;
         unsigned_q     <= 1'b0;
         addr_q         <= {ADDR_W{1'b0}};
         off_q          <= {OFF_W{1'b0}};
         wstrb_q        <= {STRB_W{1'b0}};
         wdata_q        <= {DATA_W{1'b0}};
         result_valid_q <= 1'b0;
         adel_q         <= 1'b0;
         ades_q         <= 1'b0;
         mis_pend_q     <= 1'b0;
         load_data_q    <= {DATA_W{1'b0}};
         bad_vaddr_q    <= {ADDR_W{1'b0}};
      end else begin
         state_q        <= state_d;
         req_q          <= req_d;
         store_q        <= store_d;
         size_q         <= size_d;
         unsigned_q     <= unsigned_d;
         addr_q         <= addr_d;
         off_q          <= off_d;
         wstrb_q        <= wstrb_d;
         wdata_q        <= wdata_d;
         result_valid_q <= result_valid_d;
         adel_q         <= adel_d;
         ades_q         <= ades_d;
         mis_pend_q     <= mis_pend_d;
         load_data_q    <= load_data_d;
         bad_vaddr_q    <= bad_vaddr_d;
      end
   end

   // A local fault result is withdrawn if flush arrives in its output cycle.
   assign mis_kill     = mis_pend_q & flush;
   assign result_valid = result_valid_q & ~mis_kill;
   assign adel         = adel_q & ~mis_kill;
   assign ades         = ades_q & ~mis_kill;
   assign load_data    = load_data_q;
   assign bad_vaddr    = bad_vaddr_q;
   assign op_ready     = (state_q == S_IDLE);

   assign bus.data_req   = req_q;
   assign bus.data_wr    = store_q;
   assign bus.data_size  = size_q;
   assign bus.data_addr  = addr_q;
   assign bus.data_wstrb = wstrb_q;
   assign bus.data_wdata = wdata_q;

`ifdef MEM_ACCESS_PERF_EN
   logic [31:0] acc_cnt_q, acc_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Count bus handshakes and busy cycles; both wrap naturally.
   always_comb begin
      if (req_q && bus.data_addr_ok) begin
         acc_cnt_d = acc_cnt_q + 32'd1;
      end else begin
         acc_cnt_d = acc_cnt_q;
      end
      if (state_q != S_IDLE) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         acc_cnt_q   <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         acc_cnt_q   <= acc_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_access_cnt = acc_cnt_q;
   assign perf_stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench with a 32-bit and a 64-bit instance.
// Stimulus pushes expected results into per-instance queues; a monitor
// forked from the same initial block pops and compares on each result pulse.
module tb_mem_access_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetn;

   logic        a_op_valid, a_op_store, a_op_unsigned, a_flush;
   logic [1:0]  a_op_size;
   logic [31:0] a_op_addr, a_op_wdata;
   logic        a_op_ready, a_result_valid, a_adel, a_ades;
   logic [31:0] a_load_data, a_bad_vaddr;

   logic        b_op_valid, b_op_store, b_op_unsigned, b_flush;
   logic [1:0]  b_op_size;
   logic [31:0] b_op_addr;
   logic [63:0] b_op_wdata;
   logic        b_op_ready, b_result_valid, b_adel, b_ades;
   logic [63:0] b_load_data;
   logic [31:0] b_bad_vaddr;

`ifdef MEM_ACCESS_PERF_EN
   logic [31:0] a_perf_acc, a_perf_stall, b_perf_acc, b_perf_stall;
`endif

   mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) a_bus ();
   mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) b_bus ();

   mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u_a (
      .clk(clk), .resetn(resetn),
      .op_valid(a_op_valid), .op_ready(a_op_ready), .op_store(a_op_store),
      .op_size(a_op_size), .op_unsigned(a_op_unsigned), .op_addr(a_op_addr),
      .op_wdata(a_op_wdata), .flush(a_flush),
      .result_valid(a_result_valid), .load_data(a_load_data),
      .adel(a_adel), .ades(a_ades), .bad_vaddr(a_bad_vaddr),
`ifdef MEM_ACCESS_PERF_EN
      .perf_access_cnt(a_perf_acc), .perf_stall_cnt(a_perf_stall),
`endif
      .bus(a_bus)
   );

   mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u_b (
      .clk(clk), .resetn(resetn),
      .op_valid(b_op_valid), .op_ready(b_op_ready), .op_store(b_op_store),
      .op_size(b_op_size), .op_unsigned(b_op_unsigned), .op_addr(b_op_addr),
      .op_wdata(b_op_wdata), .flush(b_flush),
      .result_valid(b_result_valid), .load_data(b_load_data),
      .adel(b_adel), .ades(b_ades), .bad_vaddr(b_bad_vaddr),
`ifdef MEM_ACCESS_PERF_EN
      .perf_access_cnt(b_perf_acc), .perf_stall_cnt(b_perf_stall),
`endif
      .bus(b_bus)
   );

   typedef struct packed {
      logic        adel;
      logic        ades;
      logic [63:0] data;
      logic [31:0] bad;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic a_issue(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
      a_op_valid = 1'b1; a_op_store = st; a_op_size = sz;
      a_op_unsigned = uns; a_op_addr = addr; a_op_wdata = wd;
      step();
      a_op_valid = 1'b0;
   endtask

   task automatic b_issue(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [63:0] wd);
      b_op_valid = 1'b1; b_op_store = st; b_op_size = sz;
      b_op_unsigned = uns; b_op_addr = addr; b_op_wdata = wd;
      step();
      b_op_valid = 1'b0;
   endtask

   // Zero-wait slave beat for A: addr_ok in REQ, data_ok the next cycle.
   task automatic a_slave(input logic [31:0] rd);
      a_bus.data_addr_ok = 1'b1;
      step();
      a_bus.data_addr_ok = 1'b0;
      a_bus.data_data_ok = 1'b1; a_bus.data_rdata = rd;
      step();
      a_bus.data_data_ok = 1'b0;
   endtask

   task automatic b_slave(input logic [63:0] rd);
      b_bus.data_addr_ok = 1'b1;
      step();
      b_bus.data_addr_ok = 1'b0;
      b_bus.data_data_ok = 1'b1; b_bus.data_rdata = rd;
      step();
      b_bus.data_data_ok = 1'b0;
   endtask

   initial begin
      exp_t e;
`ifdef MEM_ACCESS_PERF_EN
      logic [31:0] base_acc, base_stall;
`endif
      resetn = 1'b0;
      a_op_valid = 1'b0; a_op_store = 1'b0; a_op_size = 2'd0; a_op_unsigned = 1'b0;
      a_op_addr = 32'h0; a_op_wdata = 32'h0; a_flush = 1'b0;
      b_op_valid = 1'b0; b_op_store = 1'b0; b_op_size = 2'd0; b_op_unsigned = 1'b0;
      b_op_addr = 32'h0; b_op_wdata = 64'h0; b_flush = 1'b0;
      a_bus.data_addr_ok = 1'b0; a_bus.data_data_ok = 1'b0; a_bus.data_rdata = 32'h0;
      b_bus.data_addr_ok = 1'b0; b_bus.data_data_ok = 1'b0; b_bus.data_rdata = 64'h0;

      fork
         forever begin
            @(negedge clk);
            if (resetn === 1'b1 && a_result_valid === 1'b1) begin
               if (qa.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL a_unexpected_result: got load_data=%h adel=%b ades=%b expected no result",
                           a_load_data, a_adel, a_ades);
               end else begin
                  e = qa.pop_front();
                  chk("a_load_data", 64'(a_load_data), e.data);
                  chk("a_adel", 64'(a_adel), 64'(e.adel));
                  chk("a_ades", 64'(a_ades), 64'(e.ades));
                  if (e.adel | e.ades) chk("a_bad_vaddr", 64'(a_bad_vaddr), 64'(e.bad));
               end
            end
            if (resetn === 1'b1 && b_result_valid === 1'b1) begin
               if (qb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL b_unexpected_result: got load_data=%h adel=%b ades=%b expected no result",
                           b_load_data, b_adel, b_ades);
               end else begin
                  e = qb.pop_front();
                  chk("b_load_data", b_load_data, e.data);
                  chk("b_adel", 64'(b_adel), 64'(e.adel));
                  chk("b_ades", 64'(b_ades), 64'(e.ades));
                  if (e.adel | e.ades) chk("b_bad_vaddr", 64'(b_bad_vaddr), 64'(e.bad));
               end
            end
         end
      join_none

      step(); step();
      // reset state
      chk("rst_a_ready", 64'(a_op_ready), 64'd1);
      chk("rst_a_req", 64'(a_bus.data_req), 64'd0);
      chk("rst_a_wstrb", 64'(a_bus.data_wstrb), 64'd0);
      chk("rst_a_rv", 64'(a_result_valid), 64'd0);
      chk("rst_b_ready", 64'(b_op_ready), 64'd1);
      chk("rst_b_req", 64'(b_bus.data_req), 64'd0);
      chk("rst_b_load", b_load_data, 64'd0);
`ifdef MEM_ACCESS_PERF_EN
      chk("rst_a_perf_acc", 64'(a_perf_acc), 64'd0);
      chk("rst_a_perf_stall", 64'(a_perf_stall), 64'd0);
`endif
      resetn = 1'b1;
      step();

      // LB 0x1003, sign-extended
      qa.push_back({1'b0, 1'b0, 64'h0000_0000_FFFF_FF80, 32'h0});
      a_issue(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0);
      chk("lb_req", 64'(a_bus.data_req), 64'd1);
      chk("lb_wstrb", 64'(a_bus.data_wstrb), 64'h8);
      chk("lb_addr", 64'(a_bus.data_addr), 64'h1003);
      chk("lb_wr", 64'(a_bus.data_wr), 64'd0);
      chk("lb_ready_busy", 64'(a_op_ready), 64'd0);
      a_slave(32'h80FF_0000);
      chk("lb_latency", 64'(a_result_valid), 64'd1);
      chk("lb_ready_back", 64'(a_op_ready), 64'd1);

      // LBU 0x1003, zero-extended
      qa.push_back({1'b0, 1'b0, 64'h0000_0000_0000_0080, 32'h0});
      a_issue(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0);
      a_slave(32'h80FF_0000);
      chk("lbu_latency", 64'(a_result_valid), 64'd1);
      step();
      chk("rv_pulse", 64'(a_result_valid), 64'd0);

      // SH 0x2002: lane replication, store returns zero
      qa.push_back({1'b0, 1'b0, 64'h0, 32'h0});
      a_issue(1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234_ABCD);
      chk("sh_wstrb", 64'(a_bus.data_wstrb), 64'hC);
      chk("sh_wdata", 64'(a_bus.data_wdata), 64'hABCD_ABCD);
      chk("sh_wr", 64'(a_bus.data_wr), 64'd1);
      chk("sh_size", 64'(a_bus.data_size), 64'd1);
      a_slave(32'hDEAD_BEEF);
      chk("sh_latency", 64'(a_result_valid), 64'd1);

      // LW 0x3001 misaligned: no bus request, fault next cycle
      qa.push_back({1'b1, 1'b0, 64'h0, 32'h3001});
      a_issue(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0);
      chk("lw_mis_noreq", 64'(a_bus.data_req), 64'd0);
      chk("lw_mis_rv", 64'(a_result_valid), 64'd1);
      chk("lw_mis_ready", 64'(a_op_ready), 64'd1);
      step();
      chk("lw_mis_noreq2", 64'(a_bus.data_req), 64'd0);

      // SW 0x3002 misaligned store
      qa.push_back({1'b0, 1'b1, 64'h0, 32'h3002});
      a_issue(1'b1, 2'd2, 1'b0, 32'h3002, 32'h5555_5555);
      chk("sw_mis_rv", 64'(a_result_valid), 64'd1);
      step();

      // dword on a 32-bit bus faults even when aligned
      qa.push_back({1'b1, 1'b0, 64'h0, 32'h3000});
      a_issue(1'b0, 2'd3, 1'b0, 32'h3000, 32'h0);
      chk("ld32_noreq", 64'(a_bus.data_req), 64'd0);
      step();

      // Backpressure: addr_ok held low for 4 cycles
`ifdef MEM_ACCESS_PERF_EN
      base_acc = a_perf_acc; base_stall = a_perf_stall;
`endif
      qa.push_back({1'b0, 1'b0, 64'h0000_0000_CAFE_F00D, 32'h0});
      a_issue(1'b0, 2'd2, 1'b0, 32'h5004, 32'h0);
      for (int i = 0; i < 5; i++) begin
         chk("stall_req", 64'(a_bus.data_req), 64'd1);
         chk("stall_addr", 64'(a_bus.data_addr), 64'h5004);
         chk("stall_ready", 64'(a_op_ready), 64'd0);
         if (i < 4) step();
      end
      a_slave(32'hCAFE_F00D);
      chk("stall_rv", 64'(a_result_valid), 64'd1);
`ifdef MEM_ACCESS_PERF_EN
      chk("perf_acc_delta", 64'(a_perf_acc - base_acc), 64'd1);
      chk("perf_stall_delta", 64'(a_perf_stall - base_stall), 64'd6);
`endif

      // Flush in RESP, data_ok two cycles later: drained, no result
      a_issue(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0);
      a_bus.data_addr_ok = 1'b1;
      step();
      a_bus.data_addr_ok = 1'b0;
      a_flush = 1'b1;
      step();
      a_flush = 1'b0;
      chk("drain_ready0", 64'(a_op_ready), 64'd0);
      step();
      chk("drain_ready1", 64'(a_op_ready), 64'd0);
      a_bus.data_data_ok = 1'b1; a_bus.data_rdata = 32'h1111_2222;
      step();
      a_bus.data_data_ok = 1'b0;
      chk("drain_ready_back", 64'(a_op_ready), 64'd1);
      chk("drain_no_rv", 64'(a_result_valid), 64'd0);
      step();

      // Flush in REQ without addr_ok drops the request
      a_issue(1'b0, 2'd2, 1'b0, 32'h7000, 32'h0);
      chk("reqflush_req", 64'(a_bus.data_req), 64'd1);
      a_flush = 1'b1;
      step();
      a_flush = 1'b0;
      chk("reqflush_drop", 64'(a_bus.data_req), 64'd0);
      chk("reqflush_ready", 64'(a_op_ready), 64'd1);
      step();
      chk("reqflush_no_rv", 64'(a_result_valid), 64'd0);

      // Flush in the output cycle suppresses a misalignment fault
      a_issue(1'b0, 2'd1, 1'b0, 32'h7001, 32'h0);
      a_flush = 1'b1;
      #1;
      chk("misflush_rv", 64'(a_result_valid), 64'd0);
      chk("misflush_adel", 64'(a_adel), 64'd0);
      step();
      a_flush = 1'b0;

      // Flush in IDLE blocks the accept
      a_op_valid = 1'b1; a_op_store = 1'b0; a_op_size = 2'd2; a_op_addr = 32'h7100;
      a_flush = 1'b1;
      step();
      a_op_valid = 1'b0; a_flush = 1'b0;
      chk("idleflush_noreq", 64'(a_bus.data_req), 64'd0);
      chk("idleflush_ready", 64'(a_op_ready), 64'd1);
      chk("idleflush_no_rv", 64'(a_result_valid), 64'd0);
      step();

      // 64-bit instance: SD misaligned
      qb.push_back({1'b0, 1'b1, 64'h0, 32'h4004});
      b_issue(1'b1, 2'd3, 1'b0, 32'h4004, 64'h0);
      chk("sd_mis_noreq", 64'(b_bus.data_req), 64'd0);
      step();

      // SB 0x4005 replicated over 8 lanes
      qb.push_back({1'b0, 1'b0, 64'h0, 32'h0});
      b_issue(1'b1, 2'd0, 1'b0, 32'h4005, 64'h0123_4567_89AB_CDAB);
      chk("sb64_wstrb", 64'(b_bus.data_wstrb), 64'h20);
      chk("sb64_wdata", b_bus.data_wdata, 64'hABAB_ABAB_ABAB_ABAB);
      b_slave(64'hFFFF_FFFF_FFFF_FFFF);

      // LD 0x4008
      qb.push_back({1'b0, 1'b0, 64'h1122_3344_5566_7788, 32'h0});
      b_issue(1'b0, 2'd3, 1'b0, 32'h4008, 64'h0);
      chk("ld_wstrb", 64'(b_bus.data_wstrb), 64'hFF);
      b_slave(64'h1122_3344_5566_7788);
      chk("ld_rv", 64'(b_result_valid), 64'd1);

      // LH 0x4006 from top lane
      qb.push_back({1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 32'h0});
      b_issue(1'b0, 2'd1, 1'b0, 32'h4006, 64'h0);
      chk("lh64_wstrb", 64'(b_bus.data_wstrb), 64'hC0);
      b_slave(64'h8001_0000_0000_0000);

      // LW / LWU 0x4004 on a 64-bit bus
      qb.push_back({1'b0, 1'b0, 64'hFFFF_FFFF_9000_0000, 32'h0});
      b_issue(1'b0, 2'd2, 1'b0, 32'h4004, 64'h0);
      chk("lw64_wstrb", 64'(b_bus.data_wstrb), 64'hF0);
      b_slave(64'h9000_0000_1234_5678);
      qb.push_back({1'b0, 1'b0, 64'h0000_0000_9000_0000, 32'h0});
      b_issue(1'b0, 2'd2, 1'b1, 32'h4004, 64'h0);
      b_slave(64'h9000_0000_1234_5678);
      step();

      // Reset while in RESP
      b_issue(1'b1, 2'd3, 1'b0, 32'h4010, 64'hFEED_FACE_0BAD_F00D);
      b_bus.data_addr_ok = 1'b1;
      step();
      b_bus.data_addr_ok = 1'b0;
      chk("rstresp_in_resp", 64'(b_op_ready), 64'd0);
      resetn = 1'b0;
      step();
      chk("rstresp_ready", 64'(b_op_ready), 64'd1);
      chk("rstresp_req", 64'(b_bus.data_req), 64'd0);
      chk("rstresp_wr", 64'(b_bus.data_wr), 64'd0);
      chk("rstresp_addr", 64'(b_bus.data_addr), 64'd0);
      chk("rstresp_wstrb", 64'(b_bus.data_wstrb), 64'd0);
      chk("rstresp_wdata", b_bus.data_wdata, 64'd0);
      chk("rstresp_rv", 64'(b_result_valid), 64'd0);
      chk("rstresp_load", b_load_data, 64'd0);
      chk("rstresp_bad", 64'(b_bad_vaddr), 64'd0);
`ifdef MEM_ACCESS_PERF_EN
      chk("rstresp_perf_acc", 64'(b_perf_acc), 64'd0);
      chk("rstresp_perf_stall", 64'(b_perf_stall), 64'd0);
`endif
      resetn = 1'b1;
      step(); step(); step();

      chk("a_queue_empty", 64'(qa.size()), 64'd0);
      chk("b_queue_empty", 64'(qb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
